// File: rtl/uart_tx_fifo.sv
// UART transmitter with built-in baud divider, configurable frame format
// and a small transmit FIFO that feeds frames back-to-back.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 104,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send,
    input  logic [7:0]                    data,
    output logic                          tx,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          ready,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0]    BIT_MAX  = 3'(DATA_BITS - 1);
    localparam logic          STOP_MAX = (STOP_BITS == 2);
    localparam logic [7:0]    DMASK    = 8'((1 << DATA_BITS) - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic            r_stop;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_tx;
    logic            r_ovf;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    state_t          w_next;
    logic [CW-1:0]   w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic            w_stop_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_par_nxt;
    logic            w_tx_nxt;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic            w_has;
    logic            w_tick;
    logic [7:0]      w_head;

    assign w_full = (r_level == LVL_FULL);
    assign w_has  = (r_level != '0);
    assign w_push = send && !w_full;
    assign w_tick = (r_baud == BAUD_MAX);
    assign w_head = r_mem[r_rd_ptr] & DMASK;

    always_comb begin
        w_next      = r_state;
        w_baud_nxt  = r_baud + CW'(1);
        w_bit_nxt   = r_bit;
        w_stop_nxt  = r_stop;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (w_has) begin
                    w_pop    = 1'b1;
                    w_next   = S_START;
                    w_tx_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = '0;
                    w_next     = S_DATA;
                    w_tx_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
                    if (r_bit == BIT_MAX) begin
                        w_stop_nxt = 1'b0;
                        if (PARITY != 0) begin
                            w_next   = S_PARITY;
                            w_tx_nxt = r_par;
                        end else begin
                            w_next   = S_STOP;
                            w_tx_nxt = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
                    w_next     = S_STOP;
                    w_tx_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
                    if (r_stop == STOP_MAX) begin
                        // Chain straight into the next start bit when data waits
                        if (w_has) begin
                            w_pop    = 1'b1;
                            w_next   = S_START;
                            w_tx_nxt = 1'b0;
                        end else begin
                            w_next   = S_IDLE;
                            w_tx_nxt = 1'b1;
                        end
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
            end
        endcase
        if (w_pop) begin
            w_shift_nxt = w_head;
            w_par_nxt   = (PARITY == 1) ? ~^w_head : ^w_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_stop  <= w_stop_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + {{AW{1'b0}}, w_push}
                               - {{AW{1'b0}}, w_pop};
            if (send && w_full) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data;
    end

    assign tx       = r_tx;
    assign full     = w_full;
    assign level    = r_level;
    assign busy     = (r_state != S_IDLE);
    assign ready    = (r_state == S_IDLE) && !w_has;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: four frame formats driven in lockstep and compared
// every clock against a frame-level reference model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] data;

    logic       tx_o    [4];
    logic       full_o  [4];
    logic       busy_o  [4];
    logic       ready_o [4];
    logic       ovf_o   [4];
    logic [2:0] lvl_o   [4];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .tx(tx_o[0]), .full(full_o[0]), .level(lvl_o[0]),
        .busy(busy_o[0]), .ready(ready_o[0]), .overflow(ovf_o[0]));

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .tx(tx_o[1]), .full(full_o[1]), .level(lvl_o[1]),
        .busy(busy_o[1]), .ready(ready_o[1]), .overflow(ovf_o[1]));

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .tx(tx_o[2]), .full(full_o[2]), .level(lvl_o[2]),
        .busy(busy_o[2]), .ready(ready_o[2]), .overflow(ovf_o[2]));

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_5n2 (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .tx(tx_o[3]), .full(full_o[3]), .level(lvl_o[3]),
        .busy(busy_o[3]), .ready(ready_o[3]), .overflow(ovf_o[3]));

    int n_tests = 0;
    int n_fail  = 0;

    int cd  [4];
    int db  [4];
    int par [4];
    int sb  [4];
    int dep [4];

    // Reference model: pending bytes, current frame byte, clocks into frame
    logic [7:0] m_q    [4][8];
    int         m_cnt  [4];
    logic       m_busy [4];
    logic [7:0] m_cur  [4];
    int         m_t    [4];
    logic       m_ovf  [4];

    logic [11:0] cap  [4];
    int          bcnt [4];
    int          hi;

    function automatic int flen(input int i);
        return (1 + db[i] + ((par[i] != 0) ? 1 : 0) + sb[i]) * cd[i];
    endfunction

    function automatic logic exp_tx(input int i);
        int slot;
        logic [7:0] d;
        if (!m_busy[i]) return 1'b1;
        slot = m_t[i] / cd[i];
        d = m_cur[i] & 8'((1 << db[i]) - 1);
        if (slot == 0) return 1'b0;
        if (slot <= db[i]) return d[slot-1];
        if (par[i] != 0 && slot == db[i] + 1)
            return (par[i] == 1) ? ~^d : ^d;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input int i,
                       input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h",
                   tag, i, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_busy[i] = 1'b0;
            m_t[i]    = 0;
            m_ovf[i]  = 1'b0;
            m_cur[i]  = 8'h00;
        end
    endtask

    task automatic model_edge(input logic s, input logic [7:0] d);
        logic full_pre;
        logic fin;
        for (int i = 0; i < 4; i++) begin
            full_pre = (m_cnt[i] == dep[i]);
            fin = 1'b0;
            if (s && full_pre) m_ovf[i] = 1'b1;
            if (m_busy[i]) begin
                if (m_t[i] == flen(i) - 1) fin = 1'b1;
                else m_t[i]++;
            end
            if ((!m_busy[i] || fin) && m_cnt[i] > 0) begin
                m_cur[i] = m_q[i][0];
                for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
                m_cnt[i]--;
                m_busy[i] = 1'b1;
                m_t[i] = 0;
            end else if (fin) begin
                m_busy[i] = 1'b0;
            end
            if (s && !full_pre) begin
                m_q[i][m_cnt[i]] = d;
                m_cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            rdy = !m_busy[i] && (m_cnt[i] == 0);
            chk("tx",    i, 16'(tx_o[i]),    16'(exp_tx(i)));
            chk("level", i, 16'(lvl_o[i]),   16'(m_cnt[i]));
            chk("full",  i, 16'(full_o[i]),  16'(m_cnt[i] == dep[i]));
            chk("busy",  i, 16'(busy_o[i]),  16'(m_busy[i]));
            chk("ready", i, 16'(ready_o[i]), 16'(rdy));
            chk("ovf",   i, 16'(ovf_o[i]),   16'(m_ovf[i]));
        end
    endtask

    task automatic cycle(input logic s, input logic [7:0] d);
        send = s;
        data = d;
        @(posedge clk);
        model_edge(s, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic capture(input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            cap[i]  = '0;
            bcnt[i] = 0;
        end
        cycle(1'b1, d);
        for (int k = 0; k < 48; k++) begin
            cycle(1'b0, 8'h00);
            for (int i = 0; i < 4; i++) begin
                if (busy_o[i]) bcnt[i]++;
                if (k % 4 == 1) cap[i][k/4] = tx_o[i];
            end
        end
    endtask

    initial begin
        cd  = '{4, 4, 4, 4};
        db  = '{8, 8, 8, 5};
        par = '{0, 2, 1, 0};
        sb  = '{1, 1, 1, 2};
        dep = '{4, 4, 4, 4};
        rst  = 1'b1;
        send = 1'b0;
        data = 8'h00;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // 0x41 on every format
        capture(8'h41);
        chk("f41", 0, 16'(cap[0]), 16'hE82);
        chk("f41", 1, 16'(cap[1]), 16'hC82);
        chk("f41", 2, 16'(cap[2]), 16'hE82);
        chk("f41", 3, 16'(cap[3]), 16'hFC2);
        chk("busy_clks", 0, 16'(bcnt[0]), 16'd40);
        chk("busy_clks", 1, 16'(bcnt[1]), 16'd44);
        chk("busy_clks", 3, 16'(bcnt[3]), 16'd32);

        capture(8'h07);
        chk("f07", 0, 16'(cap[0]), 16'hE0E);
        chk("par07", 1, 16'(cap[1][9]), 16'd1);
        chk("par07", 2, 16'(cap[2][9]), 16'd0);

        capture(8'hFF);
        chk("fff", 0, 16'(cap[0]), 16'hFFE);
        chk("fff", 3, 16'(cap[3]), 16'hFFE);
        chk("busy_clks", 3, 16'(bcnt[3]), 16'd32);

        // Back-to-back frames
        cycle(1'b1, 8'h55);
        chk("b2b_lvl_a", 0, 16'(lvl_o[0]), 16'd1);
        cycle(1'b1, 8'hAA);
        chk("b2b_lvl_b", 0, 16'(lvl_o[0]), 16'd1);
        hi = 0;
        for (int k = 0; k < 90; k++) begin
            cycle(1'b0, 8'h00);
            if (k < 79 && tx_o[0]) hi++;
            if (k == 38) chk("b2b_lvl_c", 0, 16'(lvl_o[0]), 16'd1);
            if (k == 39) begin
                chk("b2b_lvl_d", 0, 16'(lvl_o[0]), 16'd0);
                chk("b2b_start", 0, 16'(tx_o[0]), 16'd0);
            end
        end
        chk("b2b_highs", 0, 16'(hi), 16'd40);

        // Overflow
        for (int j = 0; j < 6; j++) begin
            cycle(1'b1, 8'(8'h10 + j));
            if (j == 3) chk("full_4th", 0, 16'(full_o[0]), 16'd0);
            if (j == 4) chk("full_5th", 0, 16'(full_o[0]), 16'd1);
            if (j == 5) chk("ovf_6th", 0, 16'(ovf_o[0]), 16'd1);
        end
        for (int k = 0; k < 240; k++) cycle(1'b0, 8'h00);
        chk("ovf_ready", 0, 16'(ready_o[0]), 16'd1);
        chk("ovf_sticky", 0, 16'(ovf_o[0]), 16'd1);

        // Reset mid-frame
        cycle(1'b1, 8'h33);
        cycle(1'b1, 8'h44);
        cycle(1'b1, 8'h55);
        for (int k = 0; k < 10; k++) cycle(1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx",    i, 16'(tx_o[i]),    16'd1);
            chk("rst_level", i, 16'(lvl_o[i]),   16'd0);
            chk("rst_busy",  i, 16'(busy_o[i]),  16'd0);
            chk("rst_ready", i, 16'(ready_o[i]), 16'd1);
            chk("rst_ovf",   i, 16'(ovf_o[i]),   16'd0);
        end
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        for (int k = 0; k < 60; k++) cycle(1'b0, 8'h00);
        chk("post_rst_ready", 0, 16'(ready_o[0]), 16'd1);

        // Random traffic
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) == 0, 8'($urandom));
        for (int k = 0; k < 250; k++) cycle(1'b0, 8'h00);
        chk("drain_ready", 1, 16'(ready_o[1]), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
